result_display_scan: RTL and testbench
======================================

Name: result_display_scan

Overview:
- Reader side of the calculator's enabled 5-bit value registers.
- Takes a stored binary value on a load strobe and converts it to decimal with a sequential double-dabble.
- Drives a multiplexed active-low 4-digit seven-segment display with leading-zero blanking.
- Sits between the operand/result registers and the board display pins.

Parameters:
- WIDTH, 5, binary value width; legal range 1..8, so at most 3 decimal digits.
- REFRESH_CYC, 100000, clock cycles each digit slot stays lit; legal minimum 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- load  input  1  one-cycle strobe; capture value and convert it.
- value  input  WIDTH  unsigned binary value to display.
- busy  output  1  high while a conversion is in progress.
- an  output  4  digit anodes, active-low, one-hot or all-off.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset, sampled on the clk edge with rst_n=0:
  - busy=0, an=4'b1111, seg=7'b1111111.
  - Displayed digits hundreds/tens/ones = 0/0/0.
  - pending=0, FSM=IDLE, refresh counter=0, slot index=0.
- Conversion FSM (states IDLE, SHIFT):
  - IDLE + load=1: capture value into the shift register, clear the 12-bit BCD accumulator, set bit count=WIDTH, go to SHIFT; busy=1 from the next cycle.
  - SHIFT, every cycle: add 3 to any BCD nibble >=5, then shift {bcd,shift} left by 1, then decrement the count.
  - When the count reaches 0: copy the BCD into the displayed digits, go to IDLE, busy=0.
  - Latency: load on cycle N -> busy high on cycles N+1..N+WIDTH -> new digits visible in the display regs at N+WIDTH+1.
- Load while busy: set pending=1 and store value in a pending register; a later load overwrites it (last wins).
  - On completion, if pending=1, start the pending conversion immediately. busy stays high with no idle gap; pending clears.
- Load in the same cycle that a conversion completes counts as "while busy".
- Reset mid-conversion:
  - Abort the conversion, drop pending, and restore the reset values above.
  - Partial BCD never reaches the display.
- Scan:
  - The refresh counter counts 0..REFRESH_CYC-1 and wraps.
  - On wrap, the slot index increments 0->1->2->3->0.
  - Slot 0 = ones (an=1110), slot 1 = tens (1101), slot 2 = hundreds (1011), slot 3 = off (an=1111, seg=1111111).
  - an and seg are registered from the current slot, so they reflect a slot change one cycle later.
- Blanking:
  - Hundreds is blank when 0.
  - Tens is blank when hundreds=0 and tens=0.
  - Ones is always shown.
  - A blank slot keeps its anode active with seg=1111111.
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibble >9 cannot occur; decode it as all-off.
- The displayed digits change atomically; a scan in progress never shows a mixed old/new value.

Decomposition:
- Shared package calc_disp_pkg:
  - FSM state enum (IDLE, SHIFT).
  - Ten seven-segment code constants plus SEG_OFF.
  - Anode one-hot constants and AN_OFF.
- One combinational sub-module, bcd_to_seg7: 4-bit nibble in, 7-bit active-low code out. Instantiated once on the muxed digit.

Test Plan:
- Reset then load value=31 (WIDTH=5, REFRESH_CYC=4):
  - busy high exactly 5 cycles.
  - Slots show ones=1111001, tens=0110000, hundreds blank 1111111, slot 3 an=1111.
- value=0:
  - Ones shows 1000000.
  - Tens and hundreds show 1111111 while their anodes still cycle 1101/1011.
- Load 7, then load 12 on the 2nd busy cycle, then load 25 on the 3rd busy cycle:
  - 7 is displayed.
  - busy stays high continuously for 10 cycles.
  - Final display is 2/5; 12 is never shown.
- Load 19, assert rst_n=0 on the 3rd busy cycle:
  - Next cycle busy=0, an=1111, seg=1111111.
  - After release, ones shows 0; 19 is never displayed.
- WIDTH=8, load 255:
  - busy for 8 cycles.
  - Hundreds=0100100, tens=0010010, ones=0010010.
  - Slot dwell is exactly REFRESH_CYC cycles and slots wrap 3->0.
- WIDTH=8, load 100:
  - Tens shows 1000000 (not blanked, since hundreds≠0).
  - Ones shows 1000000, hundreds shows 1111001.

Source files
------------

// File: rtl/calc_disp_pkg.sv
// Shared types and display constants for the result display path:
// conversion FSM states, active-low segment codes and anode selects.
package calc_disp_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [3:0] AN_ONES = 4'b1110;
  localparam logic [3:0] AN_TENS = 4'b1101;
  localparam logic [3:0] AN_HUND = 4'b1011;
  localparam logic [3:0] AN_OFF  = 4'b1111;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD nibble to active-low seven-segment code; out-of-range nibbles go dark.
module bcd_to_seg7
  import calc_disp_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    case (i_nib)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/result_display_scan.sv
// Converts a loaded binary value to decimal (sequential double-dabble) and
// scans it onto a multiplexed active-low 4-digit display with leading-zero blanking.
//
// state | meaning
// IDLE  | no conversion running; display digits stable
// SHIFT | one add-3/shift step per cycle, r_cnt steps left
module result_display_scan
  import calc_disp_pkg::*;
#(
  parameter int WIDTH       = 5,
  parameter int REFRESH_CYC = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic [3:0]       an,
  output logic [6:0]       seg
);

  localparam int             CW       = (REFRESH_CYC > 2) ? $clog2(REFRESH_CYC) : 1;
  localparam logic [CW-1:0]  REF_LAST = CW'(REFRESH_CYC - 1);
  localparam logic [3:0]     CNT_INIT = 4'(WIDTH);

  state_t           r_state;
  logic             r_busy;
  logic [WIDTH-1:0] r_shift;
  logic [11:0]      r_bcd;
  logic [3:0]       r_cnt;
  logic             r_pending;
  logic [WIDTH-1:0] r_pend_val;
  logic [3:0]       r_hund;
  logic [3:0]       r_tens;
  logic [3:0]       r_ones;
  logic [CW-1:0]    r_refresh;
  logic [1:0]       r_slot;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;

  logic [11:0]      w_adj;
  logic [11:0]      w_bcd_next;
  logic [3:0]       w_digit;
  logic             w_blank;
  logic [3:0]       w_an;
  logic [6:0]       w_seg;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 3; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_bcd_next = (w_adj << 1) | 12'(r_shift[WIDTH-1]);
  end

  // Display digits are written only on the final step, so they update atomically.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_shift    <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_pending  <= 1'b0;
      r_pend_val <= '0;
      r_hund     <= '0;
      r_tens     <= '0;
      r_ones     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load) begin
            r_shift <= value;
            r_bcd   <= '0;
            r_cnt   <= CNT_INIT;
            r_state <= SHIFT;
            r_busy  <= 1'b1;
          end
        end
        SHIFT: begin
          r_bcd   <= w_bcd_next;
          r_shift <= r_shift << 1;
          r_cnt   <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_hund <= w_bcd_next[11:8];
            r_tens <= w_bcd_next[7:4];
            r_ones <= w_bcd_next[3:0];
            // A load landing on the final step is the newest pending value.
            if (load || r_pending) begin
              r_shift   <= load ? value : r_pend_val;
              r_bcd     <= '0;
              r_cnt     <= CNT_INIT;
              r_pending <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else if (load) begin
            r_pending  <= 1'b1;
            r_pend_val <= value;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_digit = r_ones;
    w_blank = 1'b0;
    w_an    = AN_ONES;
    case (r_slot)
      2'd0: w_an = AN_ONES;
      2'd1: begin
        w_digit = r_tens;
        w_blank = (r_hund == 4'd0) && (r_tens == 4'd0);
        w_an    = AN_TENS;
      end
      2'd2: begin
        w_digit = r_hund;
        w_blank = (r_hund == 4'd0);
        w_an    = AN_HUND;
      end
      default: begin
        w_blank = 1'b1;
        w_an    = AN_OFF;
      end
    endcase
  end

  bcd_to_seg7 u_seg7 (
    .i_nib (w_digit),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_refresh <= '0;
      r_slot    <= '0;
      r_an      <= AN_OFF;
      r_seg     <= SEG_OFF;
    end else begin
      if (r_refresh == REF_LAST) begin
        r_refresh <= '0;
        r_slot    <= r_slot + 2'd1;
      end else begin
        r_refresh <= r_refresh + CW'(1);
      end
      r_an  <= w_an;
      r_seg <= w_blank ? SEG_OFF : w_seg;
    end
  end

  assign busy = r_busy;
  assign an   = r_an;
  assign seg  = r_seg;

endmodule

// File: tb/tb_result_display_scan.sv
// Directed bench for result_display_scan: 5-bit and 8-bit instances, expected
// display contents queued at load time and compared after each conversion.
module tb_result_display_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load5, load8;
  logic [4:0] value5;
  logic [7:0] value8;
  logic       busy5, busy8;
  logic [3:0] an5, an8;
  logic [6:0] seg5, seg8;

  always #5 clk = ~clk;

  result_display_scan #(.WIDTH(5), .REFRESH_CYC(4)) dut5 (
    .clk(clk), .rst_n(rst_n), .load(load5), .value(value5),
    .busy(busy5), .an(an5), .seg(seg5)
  );

  result_display_scan #(.WIDTH(8), .REFRESH_CYC(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .load(load8), .value(value8),
    .busy(busy8), .an(an8), .seg(seg8)
  );

  typedef struct {
    string      tag;
    logic [6:0] o;
    logic [6:0] t;
    logic [6:0] h;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int   run5 = 0, run8 = 0, last5 = 0, last8 = 0;
  bit   saw_o2 = 0, saw_t1 = 0, saw_o9 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] d2seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic exp_t model(input string tag, input int v);
    exp_t e;
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    e.tag = tag;
    e.o   = d2seg(o);
    e.t   = (h == 0 && t == 0) ? 7'b1111111 : d2seg(t);
    e.h   = (h == 0) ? 7'b1111111 : d2seg(h);
    return e;
  endfunction

  // Busy run lengths and forbidden-digit sightings on the 5-bit display
  always @(negedge clk) begin
    if (busy5 === 1'b1) run5++;
    else begin
      if (run5 != 0) last5 = run5;
      run5 = 0;
    end
    if (busy8 === 1'b1) run8++;
    else begin
      if (run8 != 0) last8 = run8;
      run8 = 0;
    end
    if (an5 == 4'b1110 && seg5 == 7'b0100100) saw_o2 = 1;
    if (an5 == 4'b1101 && seg5 == 7'b1111001) saw_t1 = 1;
    if (an5 == 4'b1110 && seg5 == 7'b0010000) saw_o9 = 1;
  end

  task automatic load_v5(input logic [4:0] v);
    @(negedge clk);
    value5 = v;
    load5  = 1'b1;
    @(negedge clk);
    load5  = 1'b0;
  endtask

  task automatic load_v8(input logic [7:0] v);
    @(negedge clk);
    value8 = v;
    load8  = 1'b1;
    @(negedge clk);
    load8  = 1'b0;
  endtask

  task automatic wait_idle(input bit w8, input string tag);
    bit done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if ((w8 ? busy8 : busy5) == 1'b0) done = 1;
    end
    chk({tag, "_idle"}, 32'(done), 32'd1);
    @(negedge clk);
  endtask

  task automatic capture(input bit w8, output logic [6:0] co, output logic [6:0] ct,
                         output logic [6:0] ch, output logic [6:0] cf, output bit bad);
    logic [3:0] a;
    logic [6:0] s;
    co = 'x; ct = 'x; ch = 'x; cf = 'x; bad = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      a = w8 ? an8 : an5;
      s = w8 ? seg8 : seg5;
      case (a)
        4'b1110: co = s;
        4'b1101: ct = s;
        4'b1011: ch = s;
        4'b1111: cf = s;
        default: bad = 1;
      endcase
    end
  endtask

  task automatic sb_check(input bit w8);
    logic [6:0] co, ct, ch, cf;
    bit         bad;
    exp_t       e;
    capture(w8, co, ct, ch, cf, bad);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_ones"}, 32'(co), 32'(e.o));
      chk({e.tag, "_tens"}, 32'(ct), 32'(e.t));
      chk({e.tag, "_hund"}, 32'(ch), 32'(e.h));
      chk({e.tag, "_slot3_seg"}, 32'(cf), 32'h7f);
      chk({e.tag, "_an_legal"}, 32'(bad), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] prev;
    bit         got;
    bit         done;
    int         n;

    rst_n = 1'b0; load5 = 1'b0; load8 = 1'b0; value5 = '0; value8 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy5", 32'(busy5), 32'd0);
    chk("rst_an5",   32'(an5),   32'hf);
    chk("rst_seg5",  32'(seg5),  32'h7f);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_an8",   32'(an8),   32'hf);
    chk("rst_seg8",  32'(seg8),  32'h7f);
    rst_n = 1'b1;

    sb.push_back(model("v31", 31));
    load_v5(5'd31);
    wait_idle(0, "v31");
    chk("v31_busy_len", 32'(last5), 32'd5);
    sb_check(0);

    sb.push_back(model("v0", 0));
    load_v5(5'd0);
    wait_idle(0, "v0");
    chk("v0_busy_len", 32'(last5), 32'd5);
    sb_check(0);

    // Align to the ones slot so the short-lived 7 lands in a lit ones slot.
    saw_o2 = 0; saw_t1 = 0;
    got = 0; prev = an5;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      if (prev == 4'b1111 && an5 == 4'b1110) got = 1;
      prev = an5;
    end
    chk("align_slot0", 32'(got), 32'd1);
    repeat (9) @(negedge clk);
    value5 = 5'd7; load5 = 1'b1;
    @(negedge clk); load5 = 1'b0;
    @(negedge clk); value5 = 5'd12; load5 = 1'b1;
    @(negedge clk); value5 = 5'd25;
    sb.push_back(model("v25", 25));
    @(negedge clk); load5 = 1'b0;
    repeat (3) @(negedge clk);
    chk("v7_an",   32'(an5),  32'he);
    chk("v7_ones", 32'(seg5), 32'(d2seg(7)));
    wait_idle(0, "pend");
    chk("pend_busy_len", 32'(last5), 32'd10);
    chk("v12_ones_seen", 32'(saw_o2), 32'd0);
    chk("v12_tens_seen", 32'(saw_t1), 32'd0);
    sb_check(0);

    saw_o9 = 0;
    load_v5(5'd19);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy5), 32'd0);
    chk("abort_an",   32'(an5),   32'hf);
    chk("abort_seg",  32'(seg5),  32'h7f);
    rst_n = 1'b1;
    sb.push_back(model("abort", 0));
    sb_check(0);
    chk("v19_seen", 32'(saw_o9), 32'd0);
    chk("abort_stays_idle", 32'(busy5), 32'd0);

    sb.push_back(model("v255", 255));
    load_v8(8'd255);
    wait_idle(1, "v255");
    chk("v255_busy_len", 32'(last8), 32'd8);
    sb_check(1);

    got = 0; prev = an8;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      if (prev != 4'b1111 && an8 == 4'b1111) got = 1;
      prev = an8;
    end
    chk("find_slot3", 32'(got), 32'd1);
    n = 0; done = 0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      n++;
      if (an8 != 4'b1111) done = 1;
    end
    chk("dwell_slot3", 32'(n), 32'd4);
    chk("wrap_3_to_0", 32'(an8), 32'he);
    n = 0; done = 0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      n++;
      if (an8 != 4'b1110) done = 1;
    end
    chk("dwell_slot0", 32'(n), 32'd4);
    chk("slot0_to_1", 32'(an8), 32'hd);

    sb.push_back(model("v100", 100));
    load_v8(8'd100);
    wait_idle(1, "v100");
    chk("v100_busy_len", 32'(last8), 32'd8);
    sb_check(1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
